// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with per-register pending-write scoreboard, two async read ports, one write-back port.
// Saturating pending counters drive source-busy flags and the issue handshake; optional write-to-read bypass.
module reg_file_sb #(
   parameter int XLEN = 32,
   parameter int NREGS = 32,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS = 1'b1,
   parameter int MAX_PEND = 3,
   localparam int AW = $clog2(NREGS),
   localparam int PW = $clog2(MAX_PEND + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   Rs1,
   input  logic [AW-1:0]   Rs2,
   output logic [XLEN-1:0] read_data1,
   output logic [XLEN-1:0] read_data2,
   output logic            rs1_busy,
   output logic            rs2_busy,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_rd,
   output logic            issue_ready,
   input  logic            Reg_write,
   input  logic [AW-1:0]   Rd,
   input  logic [XLEN-1:0] write_data,
   output logic            wb_err
);
   localparam logic [PW-1:0] PMAX = PW'(MAX_PEND);
   localparam logic [PW-1:0] ONE = PW'(1);

   logic [XLEN-1:0] regs [NREGS];
   logic [PW-1:0]   pend [NREGS];
   logic [NREGS-1:0] inc, dec;
   logic z1, z2, zi, zd, byp1, byp2, wb_ok, issue_acc;

   assign z1 = ZERO_REG && Rs1 == '0;
   assign z2 = ZERO_REG && Rs2 == '0;
   assign zi = ZERO_REG && issue_rd == '0;
   assign zd = ZERO_REG && Rd == '0;
   assign byp1 = BYPASS && Reg_write && Rd == Rs1;
   assign byp2 = BYPASS && Reg_write && Rd == Rs2;
   assign wb_ok = Reg_write && !zd;

   assign read_data1 = z1 ? '0 : byp1 ? write_data : regs[Rs1];
   assign read_data2 = z2 ? '0 : byp2 ? write_data : regs[Rs2];
   // The final write-back of an in-flight chain resolves the hazard in the same cycle.
   assign rs1_busy = z1 ? 1'b0 : (byp1 && pend[Rs1] == ONE) ? 1'b0 : pend[Rs1] != '0;
   assign rs2_busy = z2 ? 1'b0 : (byp2 && pend[Rs2] == ONE) ? 1'b0 : pend[Rs2] != '0;

   assign issue_ready = zi || pend[issue_rd] != PMAX || (Reg_write && Rd == issue_rd);
   assign issue_acc = issue_valid && issue_ready && !zi;

   always_comb begin
      inc = '0;
      dec = '0;
      for (int r = 0; r < NREGS; r++) begin
         inc[r] = issue_acc && issue_rd == AW'(r);
         dec[r] = wb_ok && Rd == AW'(r) && pend[r] != '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_err <= 1'b0;
         for (int r = 0; r < NREGS; r++) begin
            regs[r] <= '0;
            pend[r] <= '0;
         end
      end else begin
         if (wb_ok) regs[Rd] <= write_data;
         if (wb_ok && pend[Rd] == '0 && !(issue_acc && issue_rd == Rd)) wb_err <= 1'b1;
         for (int r = 0; r < NREGS; r++) begin
            if (inc[r] && !dec[r]) pend[r] <= pend[r] + ONE;
            else if (dec[r] && !inc[r]) pend[r] <= pend[r] - ONE;
         end
      end
   end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed self-checking bench for reg_file_sb with default parameters.
module tb_reg_file_sb;
   logic clk = 1'b0;
   logic rst, issue_valid, Reg_write, issue_ready, rs1_busy, rs2_busy, wb_err;
   logic [4:0] Rs1, Rs2, issue_rd, Rd;
   logic [31:0] read_data1, read_data2, write_data;
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   reg_file_sb dut (
      .clk(clk), .rst(rst), .Rs1(Rs1), .Rs2(Rs2),
      .read_data1(read_data1), .read_data2(read_data2),
      .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
      .Reg_write(Reg_write), .Rd(Rd), .write_data(write_data), .wb_err(wb_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst = 1'b0; issue_valid = 1'b0; issue_rd = '0; Reg_write = 1'b0; Rd = '0; write_data = '0;
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1; Reg_write = 1'b1; Rd = 5'd4; write_data = 32'hFFFF;
      tick();
      idle();
      for (int i = 0; i < 32; i++) begin
         Rs1 = 5'(i); Rs2 = 5'(31 - i);
         #1;
         total++;
         if (read_data1 !== 32'h0 || read_data2 !== 32'h0) begin
            bad++; $display("FAIL reset_read[%0d] got=%h/%h exp=0/0", i, read_data1, read_data2);
         end
         total++;
         if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
            bad++; $display("FAIL reset_busy[%0d] got=%b/%b exp=0/0", i, rs1_busy, rs2_busy);
         end
      end
      issue_rd = 5'd9;
      #1;
      total++;
      if (wb_err !== 1'b0 || issue_ready !== 1'b1) begin
         bad++; $display("FAIL reset_flags wb_err=%b issue_ready=%b exp 0/1", wb_err, issue_ready);
      end
   endtask

   task automatic test_pending_bypass();
      idle();
      issue_valid = 1'b1; issue_rd = 5'd5;
      tick();
      tick();
      idle();
      Rs1 = 5'd5; Rs2 = 5'd5;
      #1;
      total++;
      if (rs1_busy !== 1'b1) begin bad++; $display("FAIL pb_busy_after_issue got=%b exp=1", rs1_busy); end
      Reg_write = 1'b1; Rd = 5'd5; write_data = 32'h11;
      #1;
      total++;
      if (read_data1 !== 32'h11 || rs1_busy !== 1'b1) begin
         bad++; $display("FAIL pb_first_wb got=%h busy=%b exp=11 busy=1", read_data1, rs1_busy);
      end
      tick();
      idle();
      #1;
      total++;
      if (read_data1 !== 32'h11 || rs1_busy !== 1'b1) begin
         bad++; $display("FAIL pb_after_first got=%h busy=%b exp=11 busy=1", read_data1, rs1_busy);
      end
      Reg_write = 1'b1; Rd = 5'd5; write_data = 32'h22;
      #1;
      total++;
      if (read_data1 !== 32'h22 || rs1_busy !== 1'b0) begin
         bad++; $display("FAIL pb_second_bypass got=%h busy=%b exp=22 busy=0", read_data1, rs1_busy);
      end
      total++;
      if (read_data2 !== 32'h22 || rs2_busy !== 1'b0) begin
         bad++; $display("FAIL pb_port2_match got=%h busy=%b exp=22 busy=0", read_data2, rs2_busy);
      end
      tick();
      idle();
      #1;
      total++;
      if (read_data1 !== 32'h22 || rs1_busy !== 1'b0 || wb_err !== 1'b0) begin
         bad++; $display("FAIL pb_settled got=%h busy=%b err=%b exp=22/0/0", read_data1, rs1_busy, wb_err);
      end
   endtask

   task automatic test_saturation();
      idle();
      issue_valid = 1'b1; issue_rd = 5'd7; Rs1 = 5'd7;
      tick(); tick(); tick();
      #1;
      total++;
      if (issue_ready !== 1'b0) begin bad++; $display("FAIL sat_ready_4th got=%b exp=0", issue_ready); end
      tick();
      total++;
      if (issue_ready !== 1'b0 || rs1_busy !== 1'b1) begin
         bad++; $display("FAIL sat_held ready=%b busy=%b exp=0/1", issue_ready, rs1_busy);
      end
      Reg_write = 1'b1; Rd = 5'd7; write_data = 32'h77;
      #1;
      total++;
      if (issue_ready !== 1'b1) begin bad++; $display("FAIL sat_wb_frees got=%b exp=1", issue_ready); end
      tick();
      idle();
      issue_rd = 5'd7;
      #1;
      total++;
      if (issue_ready !== 1'b0 || read_data1 !== 32'h77) begin
         bad++; $display("FAIL sat_still_full ready=%b data=%h exp=0/77", issue_ready, read_data1);
      end
      for (int k = 0; k < 3; k++) begin
         Reg_write = 1'b1; Rd = 5'd7; write_data = 32'(k);
         tick();
      end
      idle();
      #1;
      total++;
      if (rs1_busy !== 1'b0 || issue_ready !== 1'b1 || wb_err !== 1'b0) begin
         bad++; $display("FAIL sat_drained busy=%b ready=%b err=%b exp=0/1/0", rs1_busy, issue_ready, wb_err);
      end
   endtask

   task automatic test_zero_reg();
      idle();
      Reg_write = 1'b1; Rd = 5'd0; write_data = 32'hDEAD; Rs1 = 5'd0; Rs2 = 5'd0;
      #1;
      total++;
      if (read_data1 !== 32'h0 || read_data2 !== 32'h0) begin
         bad++; $display("FAIL zero_bypass got=%h/%h exp=0/0", read_data1, read_data2);
      end
      tick();
      idle();
      #1;
      total++;
      if (read_data1 !== 32'h0 || read_data2 !== 32'h0 || rs1_busy !== 1'b0 || rs2_busy !== 1'b0 || wb_err !== 1'b0) begin
         bad++; $display("FAIL zero_after_wr got=%h/%h busy=%b/%b err=%b exp=0/0 0/0 0", read_data1, read_data2, rs1_busy, rs2_busy, wb_err);
      end
      issue_valid = 1'b1; issue_rd = 5'd0;
      #1;
      total++;
      if (issue_ready !== 1'b1) begin bad++; $display("FAIL zero_issue_ready got=%b exp=1", issue_ready); end
      tick(); tick(); tick(); tick();
      idle();
      #1;
      total++;
      if (rs1_busy !== 1'b0 || issue_ready !== 1'b1) begin
         bad++; $display("FAIL zero_issue_nochange busy=%b ready=%b exp=0/1", rs1_busy, issue_ready);
      end
   endtask

   task automatic test_underflow();
      idle();
      Reg_write = 1'b1; Rd = 5'd9; write_data = 32'h99; Rs1 = 5'd9;
      tick();
      idle();
      #1;
      total++;
      if (read_data1 !== 32'h99 || wb_err !== 1'b1 || rs1_busy !== 1'b0) begin
         bad++; $display("FAIL uf_set data=%h err=%b busy=%b exp=99/1/0", read_data1, wb_err, rs1_busy);
      end
      tick(); tick();
      total++;
      if (wb_err !== 1'b1) begin bad++; $display("FAIL uf_sticky got=%b exp=1", wb_err); end
      rst = 1'b1;
      tick();
      idle();
      #1;
      total++;
      if (wb_err !== 1'b0 || read_data1 !== 32'h0) begin
         bad++; $display("FAIL uf_cleared err=%b data=%h exp=0/0", wb_err, read_data1);
      end
   endtask

   task automatic test_reset_override();
      idle();
      rst = 1'b1; issue_valid = 1'b1; issue_rd = 5'd3; Reg_write = 1'b1; Rd = 5'd3; write_data = 32'h55;
      tick();
      idle();
      Rs1 = 5'd3; issue_rd = 5'd3;
      #1;
      total++;
      if (read_data1 !== 32'h0 || rs1_busy !== 1'b0 || wb_err !== 1'b0 || issue_ready !== 1'b1) begin
         bad++; $display("FAIL rst_override data=%h busy=%b err=%b ready=%b exp=0/0/0/1", read_data1, rs1_busy, wb_err, issue_ready);
      end
   endtask

   task automatic test_back_to_back();
      idle();
      Reg_write = 1'b1; Rd = 5'd1; write_data = 32'h1234;
      tick();
      Rd = 5'd2; write_data = 32'h5678;
      tick();
      Reg_write = 1'b0;
      Rs1 = 5'd1; Rs2 = 5'd2;
      #1;
      total++;
      if (read_data1 !== 32'h1234 || read_data2 !== 32'h5678) begin
         bad++; $display("FAIL b2b_reads got=%h/%h exp=1234/5678", read_data1, read_data2);
      end
      rst = 1'b1;
      tick();
      idle();
      issue_valid = 1'b1; issue_rd = 5'd12; Reg_write = 1'b1; Rd = 5'd12; write_data = 32'hC;
      Rs1 = 5'd12;
      #1;
      total++;
      if (rs1_busy !== 1'b0) begin bad++; $display("FAIL b2b_same_issue_busy got=%b exp=0", rs1_busy); end
      tick();
      idle();
      #1;
      total++;
      if (rs1_busy !== 1'b1 || wb_err !== 1'b0 || read_data1 !== 32'hC) begin
         bad++; $display("FAIL b2b_issue_wb busy=%b err=%b data=%h exp=1/0/c", rs1_busy, wb_err, read_data1);
      end
   endtask

   initial begin
      idle();
      Rs1 = '0; Rs2 = '0;
      test_reset();
      test_pending_bypass();
      test_saturation();
      test_zero_reg();
      test_underflow();
      test_reset_override();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
